// File: rtl/fifo_pkg.sv
// Shared sizing helpers and error-flag type for the flexible-depth synchronous FIFO.
package fifo_pkg;

  function automatic int ptr_w(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic overflow;
    logic underflow;
  } err_flags_t;

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Address pointer that wraps from DEPTH-1 back to 0 for any DEPTH, power of two or not.
module fifo_wrap_ptr
  import fifo_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      inc,
  output logic [ptr_w(DEPTH)-1:0]   ptr
);

  localparam int AW = ptr_w(DEPTH);

  logic [AW-1:0] r_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (inc) begin
      r_ptr <= (r_ptr == AW'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
    end
  end

  assign ptr = r_ptr;

endmodule

// File: rtl/fifo_sync_flex.sv
// Single-clock FIFO with arbitrary depth, threshold flags and sticky error flags.
// Define FIFO_SYNC_FWFT_EN for first-word-fall-through reads; default is 1-cycle registered reads.
module fifo_sync_flex
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AFULL_TH   = DEPTH - 1,
  parameter int AEMPTY_TH  = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic                         rd_en,
  output logic [DATA_WIDTH-1:0]        rdata,
  output logic                         rvalid,
  output logic                         empty,
  output logic                         full,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow,
  input  logic                         clr_err
);

  localparam int AW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  if (DEPTH < 2) begin : g_bad_depth
    $error("fifo_sync_flex: DEPTH must be at least 2");
  end
  if (AFULL_TH > DEPTH) begin : g_bad_afull
    $error("fifo_sync_flex: AFULL_TH must not exceed DEPTH");
  end
  if (AEMPTY_TH >= DEPTH) begin : g_bad_aempty
    $error("fifo_sync_flex: AEMPTY_TH must be below DEPTH");
  end

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         w_wptr;
  logic [AW-1:0]         w_rptr;
  logic [CW-1:0]         r_count;
  err_flags_t            r_err;
  err_flags_t            w_err_nxt;
  logic                  w_rd_acc;
  logic                  w_wr_acc;

  // A write into a full FIFO is allowed only when a pop frees the slot in the same cycle.
  assign w_rd_acc = rd_en & ~empty;
  assign w_wr_acc = wr_en & (~full | w_rd_acc);

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wptr (
    .clk (clk),
    .rst (rst),
    .inc (w_wr_acc),
    .ptr (w_wptr)
  );

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rptr (
    .clk (clk),
    .rst (rst),
    .inc (w_rd_acc),
    .ptr (w_rptr)
  );

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[w_wptr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_wr_acc && !w_rd_acc) begin
      r_count <= r_count + 1'b1;
    end else if (w_rd_acc && !w_wr_acc) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign count        = r_count;
  assign empty        = (r_count == '0);
  assign full         = (r_count == CW'(DEPTH));
  assign almost_full  = (r_count >= CW'(AFULL_TH));
  assign almost_empty = (r_count <= CW'(AEMPTY_TH));

  // A fresh error in the clearing cycle takes priority so it is never lost.
  always_comb begin
    w_err_nxt           = r_err;
    w_err_nxt.overflow  = (r_err.overflow  & ~clr_err) | (wr_en & ~w_wr_acc);
    w_err_nxt.underflow = (r_err.underflow & ~clr_err) | (rd_en & ~w_rd_acc);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= '0;
    end else begin
      r_err <= w_err_nxt;
    end
  end

  assign overflow  = r_err.overflow;
  assign underflow = r_err.underflow;

`ifdef FIFO_SYNC_FWFT_EN
  assign rdata  = empty ? '0 : r_mem[w_rptr];
  assign rvalid = ~empty;
`else
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rvalid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_rd_acc;
      if (w_rd_acc) begin
        r_rdata <= r_mem[w_rptr];
      end
    end
  end

  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;
`endif

endmodule
